// File: rtl/fetch_pc_ctrl_if.sv
// Bundle of signals between the fetch sequencer, instruction memory, decode and execute.
// The master modport is the fetch sequencer's view; slave is the surrounding environment.
interface fetch_pc_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst_data;
  logic [WIDTH-1:0] inst_pc;
  logic             branch;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] branch_imm;
  logic             fetch_err;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, fetch_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           branch, branch_pc, branch_imm
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, fetch_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           branch, branch_pc, branch_imm
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction fetch at a time, hands the
// instruction to decode, and applies execute-stage branch redirects.
module fetch_pc_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             discard_q, discard_d;
  logic [31:0]      inst_data_q, inst_data_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic             fetch_err_q, fetch_err_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] target_pc;
  logic             target_bad;

  assign seq_pc     = pc_q + WIDTH'(4);
  assign target_pc  = bus.branch_pc + bus.branch_imm;
  assign target_bad = |target_pc[1:0];

  // A redirect gates both valids in the same cycle so nothing leaves on the wrong path.
  assign bus.imem_req_valid = (state_q == S_REQ) && !bus.branch;
  assign bus.inst_valid     = (state_q == S_OUT) && !bus.branch;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.fetch_err      = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (bus.branch) begin
          if (target_bad) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d = target_pc;
          end
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.branch) begin
          if (target_bad) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d = target_pc;
            // Response already here: drop it now; otherwise remember to drop it later.
            if (bus.imem_rsp_valid) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              discard_d = 1'b1;
            end
          end
        end else if (bus.imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_data_d = bus.imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = seq_pc;
            state_d     = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (bus.branch) begin
          if (target_bad) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d    = target_pc;
            state_d = S_REQ;
          end
        end else if (bus.inst_ready) begin
          state_d = S_REQ;
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: a latency-programmable memory model plus a
// scoreboard of expected {pc, instruction} pushed on each accepted fetch.
module tb_fetch_pc_ctrl;
  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_pc_ctrl_if #(.WIDTH(W)) bus ();
  fetch_pc_ctrl #(.WIDTH(W), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_addr;
  int          mem_lat  = 1;
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  logic        o_req_valid, o_inst_valid, o_accept, o_xfer, o_err;
  logic [31:0] o_addr, o_inst_pc, o_inst_data;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a * 32'd3 + 32'h1357_9BDF;
  endfunction

  // One clock: memory drives its response, outputs are sampled, scoreboard updated.
  task automatic cycle();
    exp_t e;
    if (mem_busy && mem_cnt == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(mem_addr);
      mem_busy           = 0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (mem_busy) mem_cnt--;
    end
    #1;
    o_req_valid  = bus.imem_req_valid;
    o_inst_valid = bus.inst_valid;
    o_addr       = bus.imem_addr;
    o_inst_pc    = bus.inst_pc;
    o_inst_data  = bus.inst_data;
    o_err        = bus.fetch_err;
    o_accept     = bus.imem_req_valid && bus.imem_req_ready;
    o_xfer       = bus.inst_valid && bus.inst_ready;
    if (o_accept) begin
      tests_run++;
      if (mem_busy || o_addr !== exp_addr) begin
        tests_failed++;
        $display("FAIL req_addr: got %h (outstanding=%0d), want %h", o_addr, mem_busy, exp_addr);
      end
      e.pc   = exp_addr;
      e.data = memword(exp_addr);
      sb.push_back(e);
      mem_busy = 1;
      mem_cnt  = mem_lat - 1;
      mem_addr = o_addr;
      exp_addr = exp_addr + 32'd4;
    end
    if (o_xfer) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL xfer_unexpected: got pc %h data %h, want no transfer", o_inst_pc, o_inst_data);
      end else begin
        e = sb.pop_front();
        if (o_inst_pc !== e.pc || o_inst_data !== e.data) begin
          tests_failed++;
          $display("FAIL xfer: got pc %h data %h, want pc %h data %h",
                   o_inst_pc, o_inst_data, e.pc, e.data);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_for_accept(input string what);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!o_accept && n < 40);
    tests_run++;
    if (!o_accept) begin
      tests_failed++;
      $display("FAIL timeout_accept_%s: got no request in %0d cycles, want one", what, n);
    end
  endtask

  task automatic wait_for_valid(input string what);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!o_inst_valid && n < 40);
    tests_run++;
    if (!o_inst_valid) begin
      tests_failed++;
      $display("FAIL timeout_valid_%s: got no inst_valid in %0d cycles, want one", what, n);
    end
  endtask

  task automatic test_reset();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.branch         = 1'b0;
    bus.branch_pc      = '0;
    bus.branch_imm     = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.imem_req_valid, bus.inst_valid, bus.fetch_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_valids: got req=%b inst=%b err=%b, want 0 0 0",
               bus.imem_req_valid, bus.inst_valid, bus.fetch_err);
    end
    tests_run++;
    if (bus.imem_addr !== RPC || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got addr %h pc %h data %h, want %h 0 0",
               bus.imem_addr, bus.inst_pc, bus.inst_data, RPC);
    end
    $display("[TB] reset checked");
    rst      = 1'b0;
    exp_addr = RPC;
  endtask

  task automatic test_sequential();
    int          first_valid;
    logic [31:0] addrs[$];
    first_valid        = -1;
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    for (int n = 0; n < 13; n++) begin
      cycle();
      if (n == 0) begin
        tests_run++;
        if (o_req_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_cycle: got imem_req_valid %b, want 0", o_req_valid);
        end
      end
      if (o_inst_valid && first_valid < 0) first_valid = n;
      if (o_accept) addrs.push_back(o_addr);
    end
    tests_run++;
    if (first_valid != 3) begin
      tests_failed++;
      $display("FAIL first_valid_cycle: got %0d, want 3", first_valid);
    end
    tests_run++;
    if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
      tests_failed++;
      $display("FAIL addr_sequence: got %0d requests, want 0x0,0x4,0x8 first", addrs.size());
    end
    $display("[TB] sequential: %0d requests, first inst_valid at cycle %0d", addrs.size(), first_valid);
  endtask

  task automatic test_stall();
    logic [31:0] pc0, data0;
    bus.inst_ready = 1'b0;
    wait_for_valid("stall");
    pc0   = o_inst_pc;
    data0 = o_inst_data;
    for (int n = 0; n < 5; n++) begin
      cycle();
      tests_run++;
      if (o_inst_valid !== 1'b1 || o_inst_pc !== pc0 || o_inst_data !== data0 || o_req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid %b pc %h data %h req %b, want 1 %h %h 0",
                 o_inst_valid, o_inst_pc, o_inst_data, o_req_valid, pc0, data0);
      end
    end
    bus.inst_ready = 1'b1;
    cycle();
    tests_run++;
    if (o_xfer !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: got transfer %b, want 1", o_xfer);
    end
    $display("[TB] stall: held pc %h for 5 cycles", pc0);
  endtask

  task automatic test_branch_wait();
    mem_lat        = 2;
    bus.inst_ready = 1'b1;
    wait_for_accept("bw");
    bus.branch     = 1'b1;
    bus.branch_pc  = 32'h100;
    bus.branch_imm = 32'hFFFF_FFF0;
    cycle();
    bus.branch = 1'b0;
    sb.delete();
    exp_addr = 32'hF0;
    cycle();
    tests_run++;
    if (o_inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_response: got inst_valid %b, want 0", o_inst_valid);
    end
    wait_for_accept("bw_target");
    tests_run++;
    if (o_addr !== 32'hF0) begin
      tests_failed++;
      $display("FAIL branch_wait_target: got %h, want 000000f0", o_addr);
    end
    wait_for_valid("bw_inst");
    $display("[TB] branch in WAIT: redirected fetch at %h", o_addr);
  endtask

  task automatic test_branch_out();
    mem_lat        = 1;
    bus.inst_ready = 1'b0;
    wait_for_valid("bo");
    bus.inst_ready = 1'b1;
    bus.branch     = 1'b1;
    bus.branch_pc  = 32'h200;
    bus.branch_imm = 32'h40;
    cycle();
    tests_run++;
    if (o_inst_valid !== 1'b0 || o_xfer !== 1'b0) begin
      tests_failed++;
      $display("FAIL squash_out: got inst_valid %b transfer %b, want 0 0", o_inst_valid, o_xfer);
    end
    bus.branch = 1'b0;
    sb.delete();
    exp_addr = 32'h240;
    wait_for_accept("bo_target");
    tests_run++;
    if (o_addr !== 32'h240) begin
      tests_failed++;
      $display("FAIL branch_out_target: got %h, want 00000240", o_addr);
    end
    wait_for_valid("bo_inst");
    $display("[TB] branch in OUT: redirected fetch at %h", o_addr);
  endtask

  task automatic test_wrap();
    bus.imem_req_ready = 1'b0;
    cycle();
    tests_run++;
    if (o_req_valid !== 1'b1 || o_accept !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_hold: got valid %b accept %b, want 1 0", o_req_valid, o_accept);
    end
    bus.branch     = 1'b1;
    bus.branch_pc  = 32'hFFFF_FFF0;
    bus.branch_imm = 32'hC;
    cycle();
    tests_run++;
    if (o_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL branch_req_gate: got imem_req_valid %b, want 0", o_req_valid);
    end
    bus.branch         = 1'b0;
    bus.imem_req_ready = 1'b1;
    exp_addr           = 32'hFFFF_FFFC;
    wait_for_accept("wrap_hi");
    wait_for_valid("wrap_inst");
    wait_for_accept("wrap_zero");
    tests_run++;
    if (o_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap: got %h, want 00000000", o_addr);
    end
    wait_for_valid("wrap_done");
    $display("[TB] wrap: fetch after fffffffc at %h", o_addr);
  endtask

  task automatic test_misaligned();
    mem_lat = 3;
    wait_for_accept("mis");
    bus.branch     = 1'b1;
    bus.branch_pc  = 32'h10;
    bus.branch_imm = 32'h2;
    cycle();
    bus.branch = 1'b0;
    sb.delete();
    for (int n = 0; n < 8; n++) begin
      cycle();
      tests_run++;
      if (o_err !== 1'b1 || o_req_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_state: got err %b req %b inst %b, want 1 0 0",
                 o_err, o_req_valid, o_inst_valid);
      end
    end
    $display("[TB] misaligned: fetch_err sticky for 8 cycles");
  endtask

  task automatic test_reset_mid_wait();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.fetch_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: got fetch_err %b, want 0", bus.fetch_err);
    end
    @(negedge clk);
    rst            = 1'b0;
    mem_busy       = 0;
    mem_lat        = 1;
    exp_addr       = RPC;
    bus.inst_ready = 1'b1;
    sb.delete();
    wait_for_valid("rst_a");
    wait_for_valid("rst_b");
    mem_lat = 3;
    wait_for_accept("rst_c");
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0 || bus.imem_addr !== RPC) begin
      tests_failed++;
      $display("FAIL async_reset_regs: got pc %h data %h addr %h, want 0 0 %h",
               bus.inst_pc, bus.inst_data, bus.imem_addr, RPC);
    end
    tests_run++;
    if ({bus.imem_req_valid, bus.inst_valid, bus.fetch_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset_valids: got %b%b%b, want 000",
               bus.imem_req_valid, bus.inst_valid, bus.fetch_err);
    end
    mem_busy           = 0;
    bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_addr = RPC;
    sb.delete();
    mem_lat = 1;
    wait_for_accept("rst_restart");
    tests_run++;
    if (o_addr !== RPC) begin
      tests_failed++;
      $display("FAIL restart_addr: got %h, want %h", o_addr, RPC);
    end
    wait_for_valid("rst_restart_inst");
    $display("[TB] reset mid-WAIT: restarted at %h", o_addr);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_out();
    test_wrap();
    test_misaligned();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
